// File: rtl/dual_output_checker_if.sv
// Sample bus between the stimulus source and dual_output_checker: one strobe
// plus the operand snapshot and the two implementation outputs being compared.
interface dual_output_checker_if;
  logic        in_valid;
  logic [11:0] opnd;
  logic        o_ref;
  logic        o_dut;

  modport master (output in_valid, opnd, o_ref, o_dut);
  modport slave  (input  in_valid, opnd, o_ref, o_dut);
endinterface

// File: rtl/dual_output_checker.sv
// Compares reference and under-test outputs sample by sample after a warm-up.
// Optional first-mismatch capture registers are built when CHECKER_CAPTURE_EN is defined.
module dual_output_checker #(
  parameter int unsigned WARMUP      = 2,
  parameter int unsigned NUM_SAMPLES = 20000,
  parameter bit          STOP_ON_ERR = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  dual_output_checker_if.slave        smp,
  output logic [31:0]                 checked_cnt,
  output logic [15:0]                 err_cnt,
  output logic                        error,
  output logic                        done,
  output logic                        passed,
  output logic [1:0]                  state,
  output logic                        cap_valid,
  output logic [11:0]                 cap_opnd,
  output logic                        cap_ref,
  output logic                        cap_dut
);

  typedef enum logic [1:0] {
    WARM  = 2'b00,
    CHECK = 2'b01,
    HALT  = 2'b10,
    DONE  = 2'b11
  } state_e;

  localparam state_e RST_STATE = (WARMUP == 0) ? CHECK : WARM;

  state_e      state_q, state_d;
  logic [31:0] warm_cnt_q, warm_cnt_d;
  logic [31:0] checked_cnt_q, checked_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        error_q, error_d;
  logic        done_q, done_d;
  logic        passed_q, passed_d;
  logic        mismatch;
  logic [31:0] chk_next;

  assign mismatch = smp.o_ref != smp.o_dut;
  assign chk_next = (checked_cnt_q == 32'hFFFF_FFFF) ? checked_cnt_q : checked_cnt_q + 32'd1;

  // NOTE: every *_d gets its hold value first so no path leaves it unassigned,
  // which is what keeps this combinational block from inferring latches.
  always_comb begin
    state_d       = state_q;
    warm_cnt_d    = warm_cnt_q;
    checked_cnt_d = checked_cnt_q;
    err_cnt_d     = err_cnt_q;
    error_d       = error_q;
    if (smp.in_valid) begin
      unique case (state_q)
        WARM: begin
          if (warm_cnt_q == WARMUP - 32'd1) state_d = CHECK;
          else                              warm_cnt_d = warm_cnt_q + 32'd1;
        end
        CHECK: begin
          checked_cnt_d = chk_next;
          if (mismatch) begin
            error_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          end
          // A stopping mismatch outranks reaching the sample count.
          if (mismatch && STOP_ON_ERR)     state_d = HALT;
          else if (chk_next == NUM_SAMPLES) state_d = DONE;
        end
        default: ;
      endcase
    end
    done_d   = (state_d == DONE);
    passed_d = done_d && !error_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RST_STATE;
      warm_cnt_q    <= '0;
      checked_cnt_q <= '0;
      err_cnt_q     <= '0;
      error_q       <= 1'b0;
      done_q        <= 1'b0;
      passed_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      warm_cnt_q    <= warm_cnt_d;
      checked_cnt_q <= checked_cnt_d;
      err_cnt_q     <= err_cnt_d;
      error_q       <= error_d;
      done_q        <= done_d;
      passed_q      <= passed_d;
    end
  end

  assign state       = state_q;
  assign checked_cnt = checked_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign error       = error_q;
  assign done        = done_q;
  assign passed      = passed_q;

`ifdef CHECKER_CAPTURE_EN
  logic        cap_valid_q, cap_valid_d;
  logic [11:0] cap_opnd_q, cap_opnd_d;
  logic        cap_ref_q, cap_ref_d;
  logic        cap_dut_q, cap_dut_d;

  always_comb begin
    cap_valid_d = cap_valid_q;
    cap_opnd_d  = cap_opnd_q;
    cap_ref_d   = cap_ref_q;
    cap_dut_d   = cap_dut_q;
    if (smp.in_valid && state_q == CHECK && mismatch && !cap_valid_q) begin
      cap_valid_d = 1'b1;
      cap_opnd_d  = smp.opnd;
      cap_ref_d   = smp.o_ref;
      cap_dut_d   = smp.o_dut;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid_q <= 1'b0;
      cap_opnd_q  <= '0;
      cap_ref_q   <= 1'b0;
      cap_dut_q   <= 1'b0;
    end else begin
      cap_valid_q <= cap_valid_d;
      cap_opnd_q  <= cap_opnd_d;
      cap_ref_q   <= cap_ref_d;
      cap_dut_q   <= cap_dut_d;
    end
  end

  assign cap_valid = cap_valid_q;
  assign cap_opnd  = cap_opnd_q;
  assign cap_ref   = cap_ref_q;
  assign cap_dut   = cap_dut_q;
`else
  // The operand snapshot only feeds the capture path.
  logic unused_opnd;
  assign unused_opnd = ^smp.opnd;

  assign cap_valid = 1'b0;
  assign cap_opnd  = '0;
  assign cap_ref   = 1'b0;
  assign cap_dut   = 1'b0;
`endif

endmodule

// File: doc/dual_output_checker.md
DUAL_OUTPUT_CHECKER -- requirements
Module: dual_output_checker

Interface
REQ-001 Parameter WARMUP, default 2: number of leading valid samples that are ignored before checking starts.
REQ-002 Parameter NUM_SAMPLES, default 20000: number of checked samples after which the run completes; legal range 1..2^32-1.
REQ-003 Parameter STOP_ON_ERR, default 1: 1 = halt on first mismatch, 0 = keep checking.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  sample strobe; opnd, o_ref and o_dut are meaningful only when high.
REQ-007 opnd  in  12  operand snapshot {a,b,c,d}, 3 bits each, a in [11:9].
REQ-008 o_ref  in  1  output of reference implementation.
REQ-009 o_dut  in  1  output of implementation under test.
REQ-010 checked_cnt  out  32  compared-sample count.
REQ-011 err_cnt  out  16  mismatch count.
REQ-012 error  out  1  sticky mismatch flag.
REQ-013 done  out  1  run complete.
REQ-014 passed  out  1  done and no error.
REQ-015 state  out  2  FSM state encoding.
REQ-016 cap_valid, cap_opnd[11:0], cap_ref, cap_dut  out  first-mismatch capture.

Function
REQ-017 FSM states SHALL be WARM=00, CHECK=01, HALT=10, DONE=11; all outputs are registered, with one cycle of latency from a sampled in_valid edge.
REQ-018 Cycles with in_valid=0 SHALL change no state or output.
REQ-019 WARM SHALL consume valid samples without comparing them, and SHALL go to CHECK on the edge that accepts the WARMUP-th sample; with WARMUP=0, reset SHALL enter CHECK directly.
REQ-020 In CHECK, each valid sample SHALL increment checked_cnt; a sample with o_ref!=o_dut SHALL increment err_cnt, which saturates at 0xFFFF, and SHALL set error.
REQ-021 On a mismatch in CHECK with STOP_ON_ERR=1, the FSM SHALL go to HALT.
REQ-022 When the accepted sample makes checked_cnt equal NUM_SAMPLES, the FSM SHALL go to DONE and assert done.
REQ-023 If the NUM_SAMPLES-th sample mismatches and STOP_ON_ERR=1, HALT SHALL take priority: done=0, checked_cnt=NUM_SAMPLES.
REQ-024 passed SHALL equal done AND NOT error; with STOP_ON_ERR=0, DONE is reached with error=1 and passed=0.
REQ-025 HALT and DONE SHALL ignore in_valid and hold every output until rst.
REQ-026 checked_cnt SHALL saturate at 0xFFFFFFFF.

Reset
REQ-027 rst=1 at any edge SHALL, including mid-run, set: state=WARM (CHECK if WARMUP=0), warm-up counter=0, checked_cnt=0, err_cnt=0, error=0, done=0, passed=0, cap_valid=0, cap_opnd=0, cap_ref=0, cap_dut=0.
REQ-028 A sample presented in the same cycle as rst=1 SHALL be discarded.

Configuration
REQ-029 Macro CHECKER_CAPTURE_EN defined: the first mismatch in CHECK SHALL load cap_opnd=opnd, cap_ref=o_ref, cap_dut=o_dut and set cap_valid=1; later mismatches SHALL NOT overwrite the capture.
REQ-030 CHECKER_CAPTURE_EN undefined: no capture registers are built; cap_valid, cap_opnd, cap_ref and cap_dut SHALL be constant 0; all other behaviour is unchanged.

Verification (WARMUP=2, NUM_SAMPLES=4, STOP_ON_ERR=1, CHECKER_CAPTURE_EN defined unless stated)
REQ-031 Warm-up: 2 valid mismatching samples, then 4 matching -> error=0 throughout; checked_cnt=4, done=1, passed=1, state=11.
REQ-032 Halt: 2 warm samples, then matching, then mismatch with opnd=0x5A3, o_ref=1, o_dut=0 -> next cycle state=10, checked_cnt=2, err_cnt=1, cap_opnd=0x5A3, cap_ref=1, cap_dut=0; further samples change nothing.
REQ-033 Last-sample conflict: 4th checked sample mismatches -> state=10, done=0, checked_cnt=4, err_cnt=1.
REQ-034 STOP_ON_ERR=0, samples 2 and 3 mismatch (opnd 0x001, then 0x002) -> DONE, err_cnt=2, error=1, passed=0, cap_opnd=0x001.
REQ-035 Mid-run reset: rst pulsed after 3 checked samples with error=1 -> all outputs 0, state=00, and a new 6-sample clean run passes; in_valid gaps of 0..3 cycles SHALL not alter counts.
REQ-036 CHECKER_CAPTURE_EN undefined, REQ-032 stimulus -> same state, checked_cnt and err_cnt, all cap_* outputs 0.
